// File: rtl/serial_shift_unit_if.sv
// Control-unit <-> serial shifter bundle: start/busy/done handshake, operand and result.
// The control unit drives the master side; the shifter implements the slave side.
interface serial_shift_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] data_in;
  logic [31:0]       shamt_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_out;

  modport master (
    output start, op, data_in, shamt_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, data_in, shamt_in,
    output busy, done, data_out
  );
endinterface

// File: rtl/serial_shift_unit.sv
// Multi-cycle shifter for the multicycle MIPS datapath: one bit per clock in SHIFT.
// Optional macro SHIFT_MULTIBIT_EN: shift up to STEP bits per clock instead.
module serial_shift_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_shift_unit_if.slave   bus,
  output logic [1:0]           dbg_state
);

  // Handshake: start is sampled only while busy is low; the accepting edge
  // captures op/data_in/shamt_in. busy stays high until the state returns to
  // IDLE, and done is a single-cycle pulse marking data_out as the result.
  // start while busy (including the done cycle) is dropped, never queued.

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  if (STEP < 1 || DATA_W != (1 << SHAMT_W)) begin : g_cfg_check
    $error("serial_shift_unit: STEP must be >= 1 and DATA_W must equal 2**SHAMT_W");
  end

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [2:0]          op_q,    op_d;
  logic [SHAMT_W-1:0]  cnt_q,   cnt_d;

  logic [DATA_W-1:0]   shifted;
  logic [SHAMT_W-1:0]  step_amt;
  logic [SHAMT_W-1:0]  start_amt;
  logic                unused_shamt_hi;

  assign start_amt       = bus.shamt_in[SHAMT_W-1:0];
  assign unused_shamt_hi = ^bus.shamt_in[31:SHAMT_W];

  function automatic logic is_shift_op(input logic [2:0] o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA) ||
           (o == OP_ROR) || (o == OP_ROL);
  endfunction

  function automatic logic [DATA_W-1:0] step1(input logic [DATA_W-1:0] d,
                                              input logic [2:0]        o);
    logic [DATA_W-1:0] r;
    r = d;
    case (o)
      OP_SLL:  r = {d[DATA_W-2:0], 1'b0};
      OP_SRL:  r = {1'b0, d[DATA_W-1:1]};
      OP_SRA:  r = {d[DATA_W-1], d[DATA_W-1:1]};
      OP_ROR:  r = {d[0], d[DATA_W-1:1]};
      OP_ROL:  r = {d[DATA_W-2:0], d[DATA_W-1]};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef SHIFT_MULTIBIT_EN
  // Chain of 1-bit steps, gated so exactly min(STEP, cnt) of them take effect.
  always_comb begin
    shifted  = data_q;
    step_amt = (int'(cnt_q) < STEP) ? cnt_q : SHAMT_W'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(step_amt)) begin
        shifted = step1(shifted, op_q);
      end
    end
  end
`else
  always_comb begin
    shifted  = step1(data_q, op_q);
    step_amt = SHAMT_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          data_d = bus.data_in;
          op_d   = bus.op;
          cnt_d  = start_amt;
          // Zero amounts and pass codes finish without any shift cycles.
          if (start_amt == '0 || !is_shift_op(bus.op)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = shifted;
        cnt_d  = cnt_q - step_amt;
        if (cnt_q == step_amt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.data_out = data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Scoreboard bench for serial_shift_unit: directed cases, reset-abort case, random ops
// checked against an arithmetic reference model (result value and done timing).
module tb_serial_shift_unit;

  localparam int DATA_W = 32;
  localparam int STEP   = 4;
  localparam int CLK_P  = 10;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  serial_shift_unit_if #(.DATA_W(DATA_W)) bus ();

  serial_shift_unit #(
    .DATA_W (DATA_W),
    .SHAMT_W(5),
    .STEP   (STEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  time               exp_t_q[$];
  logic [DATA_W-1:0] last_result = '0;

  // reference model
  function automatic int ref_amount(input logic [2:0] o, input logic [31:0] s);
    if (o >= 3'd1 && o <= 3'd5) return int'(s % 32);
    return 0;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] d,
                                             input logic [31:0] s);
    int          n;
    logic [63:0] dd;
    logic [31:0] r;
    n  = ref_amount(o, s);
    dd = {d, d};
    case (o)
      3'd1: r = d << n;
      3'd2: r = d >> n;
      3'd3: r = $signed(d) >>> n;
      3'd4: begin dd = dd >> n; r = dd[31:0];  end
      3'd5: begin dd = dd << n; r = dd[63:32]; end
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] s);
    int n;
    n = ref_amount(o, s);
`ifdef SHIFT_MULTIBIT_EN
    return (n + STEP - 1) / STEP;
`else
    return n;
`endif
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: done=1 data_out=0x%08h with nothing expected at %0t",
                 bus.data_out, $time);
      end else begin
        logic [31:0] e;
        time         et;
        e  = exp_q.pop_front();
        et = exp_t_q.pop_front();
        if (bus.data_out !== e) begin
          errors++;
          $display("FAIL result: got 0x%08h expected 0x%08h at %0t", bus.data_out, e, $time);
        end
        checks++;
        if ($time != et) begin
          errors++;
          $display("FAIL done_time: done seen at %0t expected at %0t", $time, et);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle(input bit noise);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (noise) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.op       = 3'($urandom_range(0, 7));
        bus.data_in  = $urandom;
        bus.shamt_in = $urandom;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_timeout: busy=%0b still high after 45 cycles at %0t", bus.busy, $time);
    end else begin
      check_val("hold_after_done", bus.data_out, last_result);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [31:0] s,
                        input bit noise);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = o;
    bus.data_in  = d;
    bus.shamt_in = s;
    @(posedge clk);
    last_result = ref_result(o, d, s);
    exp_q.push_back(last_result);
    exp_t_q.push_back($time + time'(ref_latency(o, s) * CLK_P + CLK_P / 2));
    #1;
    bus.start    = 1'b0;
    bus.data_in  = $urandom;
    bus.shamt_in = $urandom;
    check_val("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    wait_idle(noise);
  endtask

  task automatic reset_abort_case();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 3'd1;
    bus.data_in  = 32'h0000_00F3;
    bus.shamt_in = 32'd10;
    @(posedge clk);                       // E0
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;                  // pulse across E3, must be dropped
    bus.op       = 3'd5;
    bus.data_in  = $urandom;
    bus.shamt_in = 32'd3;
    @(posedge clk);                       // E3
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);                       // E6
    #1;
    check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_val("abort_done", {31'd0, bus.done}, 32'd0);
    check_val("abort_data", bus.data_out, 32'd0);
    reset = 1'b0;
    last_result = '0;
    @(negedge clk);
    run_op(3'd1, 32'h0000_0003, 32'd4, 1'b0);  // accepted at E8
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = '0;
    bus.data_in  = '0;
    bus.shamt_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_val("reset_done", {31'd0, bus.done}, 32'd0);
    check_val("reset_data", bus.data_out, 32'd0);
    reset = 1'b0;

    run_op(3'd1, 32'h0000_0001, 32'd5,  1'b0);
    run_op(3'd3, 32'h8000_0000, 32'd31, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'd31, 1'b0);
    run_op(3'd4, 32'h1234_5678, 32'd8,  1'b0);
    run_op(3'd5, 32'h1234_5678, 32'd8,  1'b0);
    run_op(3'd1, 32'hDEAD_BEEF, 32'h20, 1'b0);
    run_op(3'd7, 32'hDEAD_BEEF, 32'h20, 1'b0);
    run_op(3'd2, 32'hF000_0000, 32'd9,  1'b0);
    run_op(3'd4, 32'hA5A5_0001, 32'd1,  1'b1);
    run_op(3'd0, 32'h0BAD_F00D, 32'd17, 1'b1);

    reset_abort_case();

    for (int i = 0; i < 60; i++) begin
      logic [31:0] s;
      s = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      run_op(3'($urandom_range(0, 7)), $urandom, s, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check_val("pending_results", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
